// File: rtl/bht_branch_predictor_if.sv
// Fetch/Execute-side signal bundle for the branch history table.
// master: core pipeline (drives PCs and resolve inputs)
// slave : predictor (drives prediction, resolve and counter outputs)
interface bht_branch_predictor_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
);
  logic [PC_WIDTH-1:0]  PCF;
  logic                 PredictedF;
  logic [PC_WIDTH-1:0]  PCE;
  logic [PC_WIDTH-1:0]  PCTargetE;
  logic [PC_WIDTH-1:0]  PCPlus4E;
  logic                 BranchE;
  logic                 JumpE;
  logic                 PredictedE;
  logic                 ActualE;
  logic                 StallE;
  logic                 Eval_branch;
  logic                 Target_sel;
  logic [PC_WIDTH-1:0]  RedirectPCE;
  logic                 Prediction_Correct;
  logic [CNT_WIDTH-1:0] BranchCount;
  logic [CNT_WIDTH-1:0] MispredictCount;

  modport master (
    output PCF, PCE, PCTargetE, PCPlus4E, BranchE, JumpE,
           PredictedE, ActualE, StallE,
    input  PredictedF, Eval_branch, Target_sel, RedirectPCE,
           Prediction_Correct, BranchCount, MispredictCount
  );

  modport slave (
    input  PCF, PCE, PCTargetE, PCPlus4E, BranchE, JumpE,
           PredictedE, ActualE, StallE,
    output PredictedF, Eval_branch, Target_sel, RedirectPCE,
           Prediction_Correct, BranchCount, MispredictCount
  );
endinterface

// File: rtl/bht_branch_predictor.sv
// PC-indexed table of saturating counters. Predicts in Fetch (combinational
// read), resolves in Execute (combinational flush/redirect), learns on the
// clock edge for conditional branches only.
// Optional macro BHT_PERF_COUNTERS_EN: implements BranchCount and
// MispredictCount; when undefined both outputs are tied to 0.
module bht_branch_predictor #(
  parameter int ENTRIES   = 64,
  parameter int CTR_BITS  = 2,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  bht_branch_predictor_if.slave bus
);

  localparam int IDX = $clog2(ENTRIES);
  // Weakly not-taken: one below the taken threshold (0 for a 1-bit counter).
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic [IDX-1:0]      rd_idx;
  logic [IDX-1:0]      wr_idx;
  logic [CTR_BITS-1:0] wr_ctr;
  logic                valid;
  logic                mispredict;
  logic                tsel;
  logic                table_we;

  assign rd_idx = bus.PCF[IDX+1:2];
  assign wr_idx = bus.PCE[IDX+1:2];
  assign wr_ctr = ctr_q[wr_idx];

  // Read returns the registered value, so a same-index update this cycle
  // is only seen after the edge.
  assign bus.PredictedF = ctr_q[rd_idx][CTR_BITS-1];

  // Resolve: stall does not gate these, so a flush is never dropped.
  assign valid                  = bus.BranchE | bus.JumpE;
  assign mispredict             = valid & (bus.PredictedE ^ bus.ActualE);
  assign tsel                   = ~(~bus.PredictedE & bus.ActualE);
  assign bus.Eval_branch        = mispredict;
  assign bus.Prediction_Correct = valid & ~(bus.PredictedE ^ bus.ActualE);
  assign bus.Target_sel         = tsel;
  assign bus.RedirectPCE        = tsel ? bus.PCPlus4E : bus.PCTargetE;

  // Jumps are always taken, so only conditional branches train the table.
  assign table_we = bus.BranchE & ~bus.StallE;

  // Saturating counter update for the Execute-stage index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else if (table_we) begin
      if (bus.ActualE) begin
        if (wr_ctr != CTR_MAX) ctr_q[wr_idx] <= wr_ctr + CTR_BITS'(1);
      end else begin
        if (wr_ctr != '0) ctr_q[wr_idx] <= wr_ctr - CTR_BITS'(1);
      end
    end
  end

`ifdef BHT_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] branch_cnt_q;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q;

  // Saturating resolved-instruction and mispredict counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (valid && !bus.StallE) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
      if (mispredict && (mispredict_cnt_q != '1))
        mispredict_cnt_q <= mispredict_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.BranchCount     = branch_cnt_q;
  assign bus.MispredictCount = mispredict_cnt_q;
`else
  assign bus.BranchCount     = '0;
  assign bus.MispredictCount = '0;
`endif

  // PC bits outside the index field do not affect the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.PCF[PC_WIDTH-1:IDX+2], bus.PCF[1:0],
                            bus.PCE[PC_WIDTH-1:IDX+2], bus.PCE[1:0]};

endmodule
